// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the packet router controller:
//   - state_e      : 4-bit controller state encoding
//   - ERR_*        : error code values reported on errCode
//   - is_timed_state() : states in which the idle-cycle watchdog runs
// -----------------------------------------------------------------------------
package router_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_WAIT_DES   = 4'd1,
        ST_LOAD_DES   = 4'd2,
        ST_WAIT_DATA  = 4'd3,
        ST_LOAD_DATA  = 4'd4,
        ST_WAIT_CHECK = 4'd5,
        ST_LOAD_CHECK = 4'd6,
        ST_WAIT_SEND  = 4'd7,
        ST_EVAL       = 4'd8,
        ST_FORWARD    = 4'd9,
        ST_DONE       = 4'd10,
        ST_ERROR      = 4'd11
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_CHECKSUM = 2'b01;
    localparam logic [1:0] ERR_BAD_PORT = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // States where the controller waits on an external event and may stall.
    function automatic logic is_timed_state(input state_e s);
        return (s == ST_WAIT_DES)  || (s == ST_WAIT_DATA) ||
               (s == ST_WAIT_CHECK) || (s == ST_WAIT_SEND) ||
               (s == ST_FORWARD);
    endfunction

endpackage

// File: rtl/router_timeout.sv
// -----------------------------------------------------------------------------
// router_timeout
// Idle-cycle watchdog for the router controller. Only present when the
// ROUTER_TIMEOUT_EN macro is defined.
// Ports:
//   clock   : rising-edge clock
//   reset   : asynchronous active-high reset
//   hold    : controller stays in the same timed state across this edge
//   expired : consecutive dwell count has reached TIMEOUT_CYC
// -----------------------------------------------------------------------------
`ifdef ROUTER_TIMEOUT_EN
module router_timeout #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic hold,
    output logic expired
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next dwell count: grow while the state holds, restart on any change.
    always_comb begin
        count_d = count_q;
        if (hold) begin
            if (count_q == 16'hFFFF) begin
                count_d = count_q;
            end else begin
                count_d = count_q + 16'd1;
            end
        end else begin
            count_d = 16'd0;
        end
    end

    // Dwell counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (int'(count_q) >= TIMEOUT_CYC);

endmodule
`endif

// File: rtl/router_ctrl_n.sv
// -----------------------------------------------------------------------------
// router_ctrl_n
// Packet router controller: sequences destination, data and checksum loads,
// evaluates the packet and grants one output port until it is accepted.
// Optional idle-cycle watchdog enabled by defining ROUTER_TIMEOUT_EN.
// Ports:
//   clock, reset                    : rising-edge clock, async active-high reset
//   enable                          : packet enable; low aborts/returns to IDLE
//   writeDes/writeData/writeCheck   : register write strobes
//   sendData, errorData, ackPort    : send request, checksum error, port accept
//   desPort                         : destination index, captured in LOAD_DES
//   enableDes/enableData/enableCheck: one-cycle register-load strobes
//   enablePort                      : one-hot output port grant (FORWARD only)
//   errorFlag, busy                 : in ERROR; not in IDLE
//   errCode                         : 00 none, 01 checksum, 10 bad port, 11 timeout
//   wordCount                       : data words loaded in current packet
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module router_ctrl_n
    import router_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int DATA_WORDS  = 4,
    parameter int TIMEOUT_CYC = 255,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 writeDes,
    input  logic                 writeData,
    input  logic                 writeCheck,
    input  logic                 sendData,
    input  logic                 errorData,
    input  logic                 ackPort,
    input  logic [PW-1:0]        desPort,
    output logic                 enableDes,
    output logic                 enableData,
    output logic                 enableCheck,
    output logic [NUM_PORTS-1:0] enablePort,
    output logic                 errorFlag,
    output logic                 busy,
    output logic [1:0]           errCode,
    output logic [7:0]           wordCount
);

    if (NUM_PORTS < 2 || NUM_PORTS > 16 || DATA_WORDS < 1 || DATA_WORDS > 255 ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
        $error("router_ctrl_n: parameter out of range");
    end

    state_e               state_q;
    state_e               state_d;
    logic [7:0]           word_count_q;
    logic [7:0]           word_count_d;
    logic [PW-1:0]        port_q;
    logic [PW-1:0]        port_d;
    logic [1:0]           err_code_q;
    logic [1:0]           err_code_d;
    logic                 timeout_s;
    logic [NUM_PORTS-1:0] port_grant_s;

`ifdef ROUTER_TIMEOUT_EN
    logic hold_s;
    logic expired_s;

    // The watchdog only accumulates while we sit in the same timed state.
    assign hold_s = is_timed_state(state_q) && (state_d == state_q);

    router_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .hold   (hold_s),
        .expired(expired_s)
    );

    assign timeout_s = expired_s && is_timed_state(state_q);
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and datapath register update. In every timed state enable
    // low wins over the watchdog, which in turn wins over the awaited strobe.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        port_d       = port_q;
        err_code_d   = err_code_q;
        if (is_timed_state(state_q) && !enable) begin
            state_d = ST_IDLE;
        end else if (timeout_s) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_TIMEOUT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_d      = ST_WAIT_DES;
                        word_count_d = 8'd0;
                        err_code_d   = ERR_NONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT_DES: begin
                    state_d = writeDes ? ST_LOAD_DES : ST_WAIT_DES;
                end
                ST_LOAD_DES: begin
                    port_d  = desPort;
                    state_d = ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    state_d = writeData ? ST_LOAD_DATA : ST_WAIT_DATA;
                end
                ST_LOAD_DATA: begin
                    word_count_d = word_count_q + 8'd1;
                    if ((int'(word_count_q) + 1) < DATA_WORDS) begin
                        state_d = ST_WAIT_DATA;
                    end else begin
                        state_d = ST_WAIT_CHECK;
                    end
                end
                ST_WAIT_CHECK: begin
                    state_d = writeCheck ? ST_LOAD_CHECK : ST_WAIT_CHECK;
                end
                ST_LOAD_CHECK: begin
                    state_d = ST_WAIT_SEND;
                end
                ST_WAIT_SEND: begin
                    state_d = sendData ? ST_EVAL : ST_WAIT_SEND;
                end
                ST_EVAL: begin
                    // A checksum error outranks a bad destination.
                    if (errorData) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_CHECKSUM;
                    end else if (int'(port_q) >= NUM_PORTS) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_BAD_PORT;
                    end else begin
                        state_d = ST_FORWARD;
                    end
                end
                ST_FORWARD: begin
                    state_d = ackPort ? ST_DONE : ST_FORWARD;
                end
                ST_DONE, ST_ERROR: begin
                    state_d = enable ? state_q : ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Controller state and packet registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            word_count_q <= 8'd0;
            port_q       <= '0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            port_q       <= port_d;
            err_code_q   <= err_code_d;
        end
    end

    // One-hot grant of the latched port while forwarding.
    always_comb begin
        port_grant_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_grant_s[i] = (state_q == ST_FORWARD) && (int'(port_q) == i);
        end
    end

    assign enableDes   = (state_q == ST_LOAD_DES);
    assign enableData  = (state_q == ST_LOAD_DATA);
    assign enableCheck = (state_q == ST_LOAD_CHECK);
    assign enablePort  = port_grant_s;
    assign errorFlag   = (state_q == ST_ERROR);
    assign busy        = (state_q != ST_IDLE);
    assign errCode     = err_code_q;
    assign wordCount   = word_count_q;

endmodule

// File: tb/tb_router_ctrl_n.sv
// -----------------------------------------------------------------------------
// tb_router_ctrl_n
// Drives two controllers (4 ports and 3 ports, 4 data words, watchdog limit 10)
// from the same stimulus and compares both against a packet-level reference
// model every cycle, plus directed scenarios with literal expectations.
// Honours ROUTER_TIMEOUT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_router_ctrl_n;

    localparam int DW     = 4;
    localparam int TO_CYC = 10;

    // Packet phases of the reference model.
    localparam int P_IDLE = 0, P_WDES = 1, P_LDES = 2, P_WDATA = 3, P_LDATA = 4,
                   P_WCHK = 5, P_LCHK = 6, P_WSEND = 7, P_EVAL = 8, P_FWD = 9,
                   P_DONE = 10, P_ERR = 11;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic enable, writeDes, writeData, writeCheck, sendData, errorData, ackPort;
    logic [1:0] desPort;

    logic d0_enableDes, d0_enableData, d0_enableCheck, d0_errorFlag, d0_busy;
    logic [3:0] d0_enablePort;
    logic [1:0] d0_errCode;
    logic [7:0] d0_wordCount;
    logic d1_enableDes, d1_enableData, d1_enableCheck, d1_errorFlag, d1_busy;
    logic [2:0] d1_enablePort;
    logic [1:0] d1_errCode;
    logic [7:0] d1_wordCount;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int st;
        int wc;
        int port;
        int err;
        int ent;
    } mstate_t;
    mstate_t m [2];

    router_ctrl_n #(.NUM_PORTS(4), .DATA_WORDS(DW), .TIMEOUT_CYC(TO_CYC)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .writeDes(writeDes),
        .writeData(writeData), .writeCheck(writeCheck), .sendData(sendData),
        .errorData(errorData), .ackPort(ackPort), .desPort(desPort),
        .enableDes(d0_enableDes), .enableData(d0_enableData), .enableCheck(d0_enableCheck),
        .enablePort(d0_enablePort), .errorFlag(d0_errorFlag), .busy(d0_busy),
        .errCode(d0_errCode), .wordCount(d0_wordCount)
    );

    router_ctrl_n #(.NUM_PORTS(3), .DATA_WORDS(DW), .TIMEOUT_CYC(TO_CYC)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .writeDes(writeDes),
        .writeData(writeData), .writeCheck(writeCheck), .sendData(sendData),
        .errorData(errorData), .ackPort(ackPort), .desPort(desPort),
        .enableDes(d1_enableDes), .enableData(d1_enableData), .enableCheck(d1_enableCheck),
        .enablePort(d1_enablePort), .errorFlag(d1_errorFlag), .busy(d1_busy),
        .errCode(d1_errCode), .wordCount(d1_wordCount)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: advance one packet phase from the rules of the protocol.
    function automatic mstate_t model_next(mstate_t c, int nports, int now);
        mstate_t n;
        logic    waiting;
        logic    expired;
        n       = c;
        waiting = (c.st == P_WDES) || (c.st == P_WDATA) || (c.st == P_WCHK) ||
                  (c.st == P_WSEND) || (c.st == P_FWD);
        expired = 1'b0;
`ifdef ROUTER_TIMEOUT_EN
        expired = (now - c.ent) > TO_CYC;
`endif
        if (waiting && !enable) begin
            n.st = P_IDLE;
        end else if (waiting && expired) begin
            n.st  = P_ERR;
            n.err = 3;
        end else begin
            case (c.st)
                P_IDLE:  if (enable) begin n.st = P_WDES; n.wc = 0; n.err = 0; end
                P_WDES:  if (writeDes) n.st = P_LDES;
                P_LDES:  begin n.port = int'(desPort); n.st = P_WDATA; end
                P_WDATA: if (writeData) n.st = P_LDATA;
                P_LDATA: begin n.wc = c.wc + 1; n.st = (n.wc < DW) ? P_WDATA : P_WCHK; end
                P_WCHK:  if (writeCheck) n.st = P_LCHK;
                P_LCHK:  n.st = P_WSEND;
                P_WSEND: if (sendData) n.st = P_EVAL;
                P_EVAL: begin
                    if (errorData) begin n.st = P_ERR; n.err = 1; end
                    else if (c.port >= nports) begin n.st = P_ERR; n.err = 2; end
                    else n.st = P_FWD;
                end
                P_FWD:   if (ackPort) n.st = P_DONE;
                P_DONE, P_ERR: if (!enable) n.st = P_IDLE;
                default: n.st = P_IDLE;
            endcase
        end
        if (n.st != c.st) n.ent = now;
        return n;
    endfunction

    function automatic logic [31:0] exp_vec(mstate_t s);
        logic [15:0] grant;
        logic [1:0]  e;
        logic [7:0]  w;
        grant = 16'd0;
        if (s.st == P_FWD) grant = 16'd1 << s.port;
        e = s.err[1:0];
        w = s.wc[7:0];
        return {1'b0, s.st == P_LDES, s.st == P_LDATA, s.st == P_LCHK, s.st == P_ERR,
                s.st != P_IDLE, e, w, grant};
    endfunction

    // Model update on the same edges the design sees.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc <= 0;
            for (int k = 0; k < 2; k++) m[k] <= '{P_IDLE, 0, 0, 0, 0};
        end else begin
            cyc <= cyc + 1;
            for (int k = 0; k < 2; k++) m[k] <= model_next(m[k], (k == 0) ? 4 : 3, cyc + 1);
        end
    end

    // Every-cycle comparison of both designs against the model.
    always @(negedge clock) begin
        check("dut0_outputs", {1'b0, d0_enableDes, d0_enableData, d0_enableCheck, d0_errorFlag,
              d0_busy, d0_errCode, d0_wordCount, 12'd0, d0_enablePort}, exp_vec(m[0]));
        check("dut1_outputs", {1'b0, d1_enableDes, d1_enableData, d1_enableCheck, d1_errorFlag,
              d1_busy, d1_errCode, d1_wordCount, 13'd0, d1_enablePort}, exp_vec(m[1]));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_pkt(input logic [1:0] port);
        enable = 1'b1;
        tick();
        writeDes = 1'b1;
        desPort  = port;
        tick();
        writeDes = 1'b0;
        tick();
    endtask

    task automatic load_words(input int n);
        for (int i = 0; i < n; i++) begin
            writeData = 1'b1;
            tick();
            writeData = 1'b0;
            tick();
        end
    endtask

    task automatic to_eval(input logic [1:0] port);
        start_pkt(port);
        load_words(DW);
        writeCheck = 1'b1;
        tick();
        writeCheck = 1'b0;
        tick();
        sendData = 1'b1;
        tick();
        sendData = 1'b0;
    endtask

    task automatic finish_pkt();
        enable = 1'b0;
        tick();
    endtask

    initial begin
        int pulses;
        int grants;
        int lim;
        enable = 1'b0; writeDes = 1'b0; writeData = 1'b0; writeCheck = 1'b0;
        sendData = 1'b0; errorData = 1'b0; ackPort = 1'b0; desPort = 2'd0;
        #1 reset = 1'b1;
        repeat (2) tick();
        check("reset_busy", {31'd0, d0_busy}, 32'd0);
        check("reset_port", {28'd0, d0_enablePort}, 32'd0);
        check("reset_code", {30'd0, d0_errCode}, 32'd0);
        check("reset_words", {24'd0, d0_wordCount}, 32'd0);
        reset = 1'b0;
        tick();

        // Clean packet to port 2, writeData held high across the data phase.
        start_pkt(2'd2);
        writeData = 1'b1;
        pulses = 0;
        repeat (10) begin
            tick();
            pulses += int'(d0_enableData);
        end
        writeData = 1'b0;
        check("data_pulses", pulses, 32'd4);
        check("word_count_full", {24'd0, d0_wordCount}, 32'd4);
        writeCheck = 1'b1;
        tick();
        check("check_strobe", {31'd0, d0_enableCheck}, 32'd1);
        writeCheck = 1'b0;
        tick();
        sendData = 1'b1;
        tick();
        sendData = 1'b0;
        tick();
        grants = 0;
        for (int i = 0; i < 3; i++) begin
            if (d0_enablePort == 4'b0100) grants++;
            if (i == 2) ackPort = 1'b1;
            tick();
        end
        ackPort = 1'b0;
        check("grant_cycles", grants, 32'd3);
        check("done_port", {28'd0, d0_enablePort}, 32'd0);
        check("done_busy", {31'd0, d0_busy}, 32'd1);
        tick();
        check("done_hold", {31'd0, d0_busy}, 32'd1);
        finish_pkt();
        check("done_to_idle", {31'd0, d0_busy}, 32'd0);

        // Checksum error outranks destination.
        to_eval(2'd3);
        errorData = 1'b1;
        tick();
        errorData = 1'b0;
        check("cksum_flag", {31'd0, d0_errorFlag}, 32'd1);
        check("cksum_code0", {30'd0, d0_errCode}, 32'd1);
        check("cksum_code1", {30'd0, d1_errCode}, 32'd1);
        check("cksum_port", {28'd0, d0_enablePort}, 32'd0);
        finish_pkt();
        check("code_held_idle", {30'd0, d0_errCode}, 32'd1);
        enable = 1'b1;
        tick();
        check("code_cleared", {30'd0, d0_errCode}, 32'd0);

        // Abort in WAIT_DATA after two words; enable low beats writeData.
        writeDes = 1'b1;
        desPort  = 2'd1;
        tick();
        writeDes = 1'b0;
        tick();
        load_words(2);
        check("two_words", {24'd0, d0_wordCount}, 32'd2);
        enable    = 1'b0;
        writeData = 1'b1;
        tick();
        writeData = 1'b0;
        check("abort_idle", {31'd0, d0_busy}, 32'd0);
        check("abort_noerr", {31'd0, d0_errorFlag}, 32'd0);
        enable = 1'b1;
        tick();
        check("restart_words", {24'd0, d0_wordCount}, 32'd0);
        finish_pkt();

        // Port 3: bad on the 3-port controller, valid on the 4-port one.
        to_eval(2'd3);
        tick();
        check("badport_flag", {31'd0, d1_errorFlag}, 32'd1);
        check("badport_code", {30'd0, d1_errCode}, 32'd2);
        check("port3_grant", {28'd0, d0_enablePort}, 32'h8);
        finish_pkt();

        // Stall in WAIT_CHECK.
        start_pkt(2'd0);
        load_words(DW);
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 10) check("stall_10", {31'd0, d0_errorFlag}, 32'd0);
        end
`ifdef ROUTER_TIMEOUT_EN
        check("timeout_flag", {31'd0, d0_errorFlag}, 32'd1);
        check("timeout_code", {30'd0, d0_errCode}, 32'd3);
`else
        check("no_timeout_flag", {31'd0, d0_errorFlag}, 32'd0);
        check("no_timeout_busy", {31'd0, d0_busy}, 32'd1);
`endif
        finish_pkt();

        // Asynchronous reset while forwarding.
        to_eval(2'd1);
        tick();
        check("fwd_port1", {28'd0, d0_enablePort}, 32'h2);
        enable = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_port", {28'd0, d0_enablePort}, 32'd0);
        check("async_busy", {31'd0, d0_busy}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Randomized traffic, alternating brisk and sluggish strobe rates.
        for (int b = 0; b < 120; b++) begin
            lim = ($urandom_range(0, 3) == 0) ? 12 : 2;
            repeat (25) begin
                enable     = ($urandom_range(0, 24) != 0);
                writeDes   = ($urandom_range(1, lim) == 1);
                writeData  = ($urandom_range(1, lim) == 1);
                writeCheck = ($urandom_range(1, lim) == 1);
                sendData   = ($urandom_range(1, lim) == 1);
                ackPort    = ($urandom_range(1, lim) == 1);
                errorData  = ($urandom_range(0, 3) == 0);
                desPort    = 2'($urandom_range(0, 3));
                tick();
            end
        end
        enable = 1'b0; writeDes = 1'b0; writeData = 1'b0; writeCheck = 1'b0;
        sendData = 1'b0; errorData = 1'b0; ackPort = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
